// File: rtl/qsys_block_nios2e_oci_trace_monitor_if.sv
// Trace drain handshake between the OCI trace monitor and whatever consumes its buffer.
// The master presents {tag, word} entries and the slave accepts them with trace_ready.
interface qsys_block_nios2e_oci_trace_monitor_if #(
    parameter int DCT_WIDTH   = 30,
    parameter int COUNT_WIDTH = 4
);
    logic [DCT_WIDTH+COUNT_WIDTH-1:0] trace_data;
    logic                             trace_valid;
    logic                             trace_ready;

    modport master (
        output trace_data,
        output trace_valid,
        input  trace_ready
    );

    modport slave (
        input  trace_data,
        input  trace_valid,
        output trace_ready
    );
endinterface

// File: rtl/qsys_block_nios2e_oci_trace_monitor.sv
// Captures tagged debug trace words into a circular buffer, then drains them in order
// over a valid/ready handshake once the test signals it is ending.
module qsys_block_nios2e_oci_trace_monitor #(
    parameter int DCT_WIDTH   = 30,
    parameter int COUNT_WIDTH = 4,
    parameter int DEPTH       = 16,
    parameter int OVERWRITE   = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DCT_WIDTH-1:0]          dct_buffer,
    input  logic [COUNT_WIDTH-1:0]        dct_count,
    input  logic                          test_ending,
    input  logic                          test_has_ended,
    qsys_block_nios2e_oci_trace_monitor_if.master trace,
    output logic [$clog2(DEPTH):0]        fill,
    output logic                          overflow,
    output logic [7:0]                    drop_count,
    output logic                          done
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = DCT_WIDTH + COUNT_WIDTH;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {CAPTURE, DRAIN, DONE} state_t;

    state_t                 state, state_n;
    logic [EW-1:0]          mem [DEPTH];
    logic [AW-1:0]          wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
    logic [AW:0]            fill_n;
    logic [COUNT_WIDTH-1:0] dct_count_q;
    logic                   overflow_n;
    logic [7:0]             drop_n;
    logic                   valid_q, valid_n;
    logic                   done_q;
    logic                   cap_event, pop, wr_en;

    always_comb begin
        cap_event  = (dct_count != dct_count_q) && (dct_count != '0);
        pop        = valid_q && trace.trace_ready;
        state_n    = state;
        fill_n     = fill;
        wr_ptr_n   = wr_ptr;
        rd_ptr_n   = rd_ptr;
        wr_en      = 1'b0;
        overflow_n = overflow;
        drop_n     = drop_count;

        case (state)
            CAPTURE: begin
                if (cap_event) begin
                    if (fill != FULL) begin
                        wr_en    = 1'b1;
                        wr_ptr_n = wr_ptr + 1'b1;
                        fill_n   = fill + 1'b1;
                    end else begin
                        overflow_n = 1'b1;
                        if (drop_count != 8'hFF) begin
                            drop_n = drop_count + 8'd1;
                        end
                        // Overwrite mode sacrifices the oldest entry; fill stays pinned at DEPTH.
                        if (OVERWRITE != 0) begin
                            wr_en    = 1'b1;
                            wr_ptr_n = wr_ptr + 1'b1;
                            rd_ptr_n = rd_ptr + 1'b1;
                        end
                    end
                end
                if (test_ending) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (pop) begin
                    rd_ptr_n = rd_ptr + 1'b1;
                    fill_n   = fill - 1'b1;
                end else if (fill == '0) begin
                    state_n = DONE;
                end
            end
            default: ;
        endcase

        // Abort wins over everything: contents are discarded, loss statistics are kept.
        if (test_has_ended) begin
            state_n    = DONE;
            fill_n     = '0;
            wr_ptr_n   = '0;
            rd_ptr_n   = '0;
            wr_en      = 1'b0;
            overflow_n = overflow;
            drop_n     = drop_count;
        end

        valid_n = (state_n == DRAIN) && (fill_n != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= CAPTURE;
            fill        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow    <= 1'b0;
            drop_count  <= 8'd0;
            dct_count_q <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_n;
            fill        <= fill_n;
            wr_ptr      <= wr_ptr_n;
            rd_ptr      <= rd_ptr_n;
            overflow    <= overflow_n;
            drop_count  <= drop_n;
            dct_count_q <= dct_count;
            valid_q     <= valid_n;
            done_q      <= (state_n == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {dct_count, dct_buffer};
        end
    end

    assign trace.trace_data  = mem[rd_ptr];
    assign trace.trace_valid = valid_q;
    assign done              = done_q;
endmodule

// File: tb/tb_qsys_block_nios2e_oci_trace_monitor.sv
// Drives a drop-newest and an overwrite-oldest monitor with identical stimulus and
// compares both against queue-based models of the capture/drain behaviour.
module tb_qsys_block_nios2e_oci_trace_monitor;
    localparam int DW    = 30;
    localparam int CW    = 4;
    localparam int EW    = DW + CW;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] dct_buffer = '0;
    logic [CW-1:0] dct_count = '0;
    logic          test_ending = 1'b0;
    logic          test_has_ended = 1'b0;
    logic          ready = 1'b0;

    logic [4:0] fill0, fill1;
    logic       overflow0, overflow1, done0, done1;
    logic [7:0] drop0, drop1;

    qsys_block_nios2e_oci_trace_monitor_if #(.DCT_WIDTH(DW), .COUNT_WIDTH(CW)) tr0 ();
    qsys_block_nios2e_oci_trace_monitor_if #(.DCT_WIDTH(DW), .COUNT_WIDTH(CW)) tr1 ();
    assign tr0.trace_ready = ready;
    assign tr1.trace_ready = ready;

    qsys_block_nios2e_oci_trace_monitor #(
        .DCT_WIDTH(DW), .COUNT_WIDTH(CW), .DEPTH(DEPTH), .OVERWRITE(0)
    ) dut0 (
        .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .test_ending(test_ending), .test_has_ended(test_has_ended), .trace(tr0),
        .fill(fill0), .overflow(overflow0), .drop_count(drop0), .done(done0)
    );

    qsys_block_nios2e_oci_trace_monitor #(
        .DCT_WIDTH(DW), .COUNT_WIDTH(CW), .DEPTH(DEPTH), .OVERWRITE(1)
    ) dut1 (
        .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .test_ending(test_ending), .test_has_ended(test_has_ended), .trace(tr1),
        .fill(fill1), .overflow(overflow1), .drop_count(drop1), .done(done1)
    );

    always #5 clk = ~clk;

    // Model: 0 = capturing, 1 = draining, 2 = finished.
    logic [EW-1:0] q0[$];
    logic [EW-1:0] q1[$];
    int            phase = 0;
    logic [CW-1:0] prev_count = '0;
    logic          m_ovf0 = 1'b0, m_ovf1 = 1'b0;
    int            m_drop0 = 0, m_drop1 = 0;

    int compared = 0;
    int mismatched = 0;

    task automatic check_val(input string name, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_capture(input logic [EW-1:0] e);
        if (q0.size() < DEPTH) q0.push_back(e);
        else begin
            m_ovf0 = 1'b1;
            if (m_drop0 < 255) m_drop0++;
        end
        if (q1.size() < DEPTH) q1.push_back(e);
        else begin
            m_ovf1 = 1'b1;
            if (m_drop1 < 255) m_drop1++;
            void'(q1.pop_front());
            q1.push_back(e);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic v0, v1;
        v0 = (phase == 1) && (q0.size() != 0);
        v1 = (phase == 1) && (q1.size() != 0);
        check_val({tag, ":fill0"}, 64'(fill0), 64'(q0.size()));
        check_val({tag, ":fill1"}, 64'(fill1), 64'(q1.size()));
        check_val({tag, ":valid0"}, 64'(tr0.trace_valid), 64'(v0));
        check_val({tag, ":valid1"}, 64'(tr1.trace_valid), 64'(v1));
        if (v0) check_val({tag, ":data0"}, 64'(tr0.trace_data), 64'(q0[0]));
        if (v1) check_val({tag, ":data1"}, 64'(tr1.trace_data), 64'(q1[0]));
        check_val({tag, ":ovf0"}, 64'(overflow0), 64'(m_ovf0));
        check_val({tag, ":ovf1"}, 64'(overflow1), 64'(m_ovf1));
        check_val({tag, ":drop0"}, 64'(drop0), 64'(m_drop0));
        check_val({tag, ":drop1"}, 64'(drop1), 64'(m_drop1));
        check_val({tag, ":done0"}, 64'(done0), 64'(phase == 2));
        check_val({tag, ":done1"}, 64'(done1), 64'(phase == 2));
    endtask

    task automatic applyStimulus(input logic [DW-1:0] b, input logic [CW-1:0] c,
                                 input logic te, input logic th, input logic rd,
                                 input logic rs, input string tag);
        logic ev;
        dct_buffer     = b;
        dct_count      = c;
        test_ending    = te;
        test_has_ended = th;
        ready          = rd;
        reset          = rs;
        if (rs) begin
            q0.delete(); q1.delete();
            phase = 0; prev_count = '0;
            m_ovf0 = 1'b0; m_ovf1 = 1'b0; m_drop0 = 0; m_drop1 = 0;
        end else begin
            ev = (c != prev_count) && (c != '0);
            if (th) begin
                phase = 2;
                q0.delete(); q1.delete();
            end else if (phase == 0) begin
                if (ev) model_capture({c, b});
                if (te) phase = 1;
            end else if (phase == 1) begin
                if (q0.size() == 0) phase = 2;
                else if (rd) begin
                    void'(q0.pop_front());
                    void'(q1.pop_front());
                end
            end
            prev_count = c;
        end
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic drain_all(input string tag);
        for (int n = 0; n < 60 && phase != 2; n++)
            applyStimulus($urandom, 4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b1, 1'b0, tag);
        check_val({tag, ":finished"}, 64'(phase), 64'd2);
    endtask

    initial begin
        // Reset state
        applyStimulus('0, '0, 0, 0, 0, 1, "reset");
        applyStimulus('0, '0, 0, 0, 0, 1, "reset");

        // Three tagged words then drain in order
        applyStimulus(30'h0AAAAAAA, 4'd1, 0, 0, 1, 0, "abc_cap");
        applyStimulus(30'h0BBBBBBB, 4'd2, 0, 0, 1, 0, "abc_cap");
        applyStimulus(30'h0CCCCCCC, 4'd3, 0, 0, 1, 0, "abc_cap");
        applyStimulus(30'h0DDDDDDD, 4'd3, 1, 0, 1, 0, "abc_end");
        drain_all("abc_drain");

        // Held tag counts once
        applyStimulus('0, '0, 0, 0, 0, 1, "hold_rst");
        for (int i = 0; i < 10; i++) applyStimulus($urandom, 4'd5, 0, 0, 0, 0, "hold5");
        applyStimulus($urandom, 4'd0, 0, 0, 0, 0, "hold0");
        applyStimulus($urandom, 4'd0, 0, 0, 0, 0, "hold0");

        // 18 events into a 16-deep buffer, both overflow policies
        applyStimulus('0, '0, 0, 0, 0, 1, "ovf_rst");
        for (int i = 0; i < 18; i++)
            applyStimulus($urandom, 4'((i % 15) + 1), 0, 0, 0, 0, "ovf_cap");
        applyStimulus($urandom, 4'd3, 1, 0, 0, 0, "ovf_end");
        drain_all("ovf_drain");

        // Ready toggling, then abort mid-drain
        applyStimulus('0, '0, 0, 0, 0, 1, "tog_rst");
        for (int i = 1; i <= 4; i++) applyStimulus($urandom, 4'(i), 0, 0, 0, 0, "tog_cap");
        applyStimulus($urandom, 4'd4, 1, 0, 0, 0, "tog_end");
        for (int i = 0; i < 5; i++) applyStimulus($urandom, 4'(i + 7), 0, 0, (i % 2) == 0, 0, "tog_drain");
        applyStimulus($urandom, 4'd1, 0, 1, 1, 0, "tog_abort");
        applyStimulus($urandom, 4'd2, 1, 0, 1, 0, "tog_done");

        // Reset while draining seven entries; last event coincides with test_ending
        applyStimulus('0, '0, 0, 0, 0, 1, "mid_rst");
        for (int i = 1; i <= 6; i++) applyStimulus($urandom, 4'(i), 0, 0, 0, 0, "mid_cap");
        applyStimulus($urandom, 4'd7, 1, 0, 0, 0, "mid_end");
        applyStimulus($urandom, 4'd7, 0, 0, 0, 0, "mid_drain");
        applyStimulus($urandom, 4'd7, 0, 0, 1, 1, "mid_reset");
        applyStimulus($urandom, 4'd7, 0, 0, 1, 0, "mid_after");

        // Drop counter saturation
        applyStimulus('0, '0, 0, 0, 0, 1, "sat_rst");
        for (int i = 0; i < 290; i++)
            applyStimulus($urandom, 4'((i % 2) + 1), 0, 0, 0, 0, "sat_cap");

        // Randomized rounds
        for (int r = 0; r < 15; r++) begin
            int end_at;
            end_at = $urandom_range(8, 40);
            applyStimulus('0, '0, 0, 0, 0, 1, "rnd_rst");
            for (int cyc = 0; cyc < 70; cyc++)
                applyStimulus($urandom, 4'($urandom_range(0, 4)), cyc == end_at,
                              $urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)),
                              $urandom_range(0, 199) == 0, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
